// File: rtl/wave_capture_buffer.sv
// wave_capture_buffer: edge-triggered, decimating single-frame capture of a waveform stream with a random-access read port
module wave_capture_buffer #(
   parameter int DATA_W  = 6,
   parameter int DEPTH   = 640,
   parameter int ADDR_W  = 10,
   parameter int TIMEOUT = 65535
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] sample_in,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] threshold,
   input  logic [7:0]        decim,
   input  logic              arm,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              frame_ready,
   output logic              busy,
   output logic              timed_out
);
   localparam logic [2:0] S_IDLE = 3'd0, S_WLOW = 3'd1, S_WTRIG = 3'd2, S_CAP = 3'd3, S_DONE = 3'd4;
   localparam logic [15:0] TO = 16'(TIMEOUT);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
   logic [2:0]        r_state;
   logic [ADDR_W-1:0] r_wptr;
   logic [7:0]        r_dcnt, r_decim;
   logic [15:0]       r_tcnt;
   logic              r_timed_out, r_oob;
   logic [DATA_W-1:0] r_ram [DEPTH];
   logic [DATA_W-1:0] r_rdq;
   logic              w_wait, w_above, w_tout, w_trig, w_cap, w_we, w_rearm;
   logic [15:0]       w_tinc;
   logic [ADDR_W-1:0] w_waddr;

   // trigger, decimation-hit and write-port decode; timeout counter saturates at TIMEOUT
   always_comb begin
      w_wait  = r_state == S_WLOW || r_state == S_WTRIG;
      w_above = sample_in >= threshold;
      w_tinc  = (r_tcnt >= TO) ? TO : r_tcnt + 16'd1;
      w_tout  = w_tinc == TO;
      w_trig  = sample_valid && ((r_state == S_WTRIG && w_above) || (w_wait && w_tout));
      w_cap   = sample_valid && r_state == S_CAP && r_dcnt == r_decim;
      w_we    = !reset && (w_trig || w_cap);
      w_waddr = w_trig ? '0 : r_wptr;
      w_rearm = arm && (r_state == S_IDLE || r_state == S_DONE);
   end

   // capture FSM; invalid samples freeze everything except arming from IDLE/DONE
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_wptr      <= '0;
         r_dcnt      <= '0;
         r_decim     <= '0;
         r_tcnt      <= '0;
         r_timed_out <= 1'b0;
      end else if (w_rearm) begin
         r_state     <= S_WLOW;
         r_wptr      <= '0;
         r_dcnt      <= '0;
         r_tcnt      <= '0;
         r_timed_out <= 1'b0;
      end else if (w_trig) begin
         r_state     <= S_CAP;
         r_wptr      <= ADDR_W'(1);
         r_dcnt      <= '0;
         r_decim     <= decim;
         r_timed_out <= !(r_state == S_WTRIG && w_above);
      end else if (sample_valid && w_wait) begin
         r_tcnt <= w_tinc;
         if (r_state == S_WLOW && !w_above) r_state <= S_WTRIG;
      end else if (sample_valid && r_state == S_CAP) begin
         r_dcnt <= w_cap ? '0 : r_dcnt + 8'd1;
         if (w_cap) begin
            r_wptr <= r_wptr + ADDR_W'(1);
            if (r_wptr == LAST) r_state <= S_DONE;
         end
      end
   end

   // sample RAM write port, write-protected outside trigger/capture
   always_ff @(posedge clk) begin
      if (w_we) r_ram[w_waddr] <= sample_in;
   end

   // synchronous RAM read, left without reset so it maps onto block RAM
   always_ff @(posedge clk) begin
      r_rdq <= r_ram[rd_addr];
   end

   // out-of-range flag masks the read data to zero; also forces zero after reset
   always_ff @(posedge clk) begin
      if (reset) r_oob <= 1'b1;
      else       r_oob <= rd_addr > LAST;
   end

   assign rd_data     = r_oob ? '0 : r_rdq;
   assign frame_ready = r_state == S_DONE;
   assign busy        = w_wait || r_state == S_CAP;
   assign timed_out   = r_timed_out;
endmodule

// File: tb/tb_wave_capture_buffer.sv
// tb_wave_capture_buffer: directed scoreboard bench for wave_capture_buffer (TIMEOUT reduced to 100)
module tb_wave_capture_buffer;
   typedef struct {int addr; logic [5:0] d;} rd_t;
   logic       clk = 1'b0, reset, arm, sample_valid, req = 1'b0, req_d = 1'b0;
   logic [5:0] sample_in, threshold, rd_data;
   logic [7:0] decim;
   logic [9:0] rd_addr;
   logic       frame_ready, busy, timed_out;
   int         checks = 0, errors = 0, nval, ncyc;
   rd_t        q_rd[$];

   wave_capture_buffer #(.DATA_W(6), .DEPTH(640), .ADDR_W(10), .TIMEOUT(100)) dut (
      .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
      .threshold(threshold), .decim(decim), .arm(arm), .rd_addr(rd_addr), .rd_data(rd_data),
      .frame_ready(frame_ready), .busy(busy), .timed_out(timed_out));

   always #5 clk = ~clk;

   // read requests are answered one clock later
   always @(posedge clk) req_d <= req;

   // monitor: pop the expected word whenever a read response is due
   always @(negedge clk) begin
      if (req_d) begin
         rd_t e;
         checks++;
         if (q_rd.size() == 0) begin
            errors++;
            $display("FAIL rd_underflow actual %0d required <none>", rd_data);
         end else begin
            e = q_rd.pop_front();
            if (rd_data !== e.d) begin
               errors++;
               $display("FAIL rd_data[%0d] actual %0d required %0d", e.addr, rd_data, e.d);
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual running required finished");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0d required %0d", name, act, exp);
      end
   endtask

   // mode 1: square 60/0 period 20; mode 2: ramp offset so post-arm sample 100 is 0; mode 3: constant 0
   function automatic logic [5:0] wave(input int mode, input int n);
      return mode == 1 ? ((n % 20) < 10 ? 6'd60 : 6'd0) : mode == 2 ? 6'((n + 28) % 64) : 6'd0;
   endfunction

   // expected frame contents by address
   function automatic logic [5:0] fexp(input int t, input int a);
      return t == 1 ? ((a % 20) < 10 ? 6'd60 : 6'd0) : t == 2 ? 6'((4 * a) % 64) : 6'd0;
   endfunction

   task automatic do_arm(input logic v);
      arm = 1'b1;
      sample_in = 6'd60;
      sample_valid = v;
      tick();
      arm = 1'b0;
   endtask

   task automatic rd(input int a, input logic [5:0] e);
      rd_addr = 10'(a);
      req = 1'b1;
      q_rd.push_back('{a, e});
      tick();
   endtask

   task automatic readback(input int t);
      for (int a = 0; a < 640; a++) rd(a, fexp(t, a));
      rd(700, 6'd0);
      rd(1023, 6'd0);
      req = 1'b0;
      tick();
      tick();
   endtask

   // feed post-arm samples n=1,2,...; counts valid samples and clocks from the trigger sample on
   task automatic run(input int mode, input bit togg, input int trig_n, input int arm_at,
                      input int stop, input logic [7:0] dec_after, output int nv, output int nc);
      int n = 1, c = 0;
      bit started = 0, v;
      nv = 0;
      nc = 0;
      while (!frame_ready && c < 4000 && !(stop > 0 && n == stop)) begin
         v = togg ? (c % 2 == 0) : 1'b1;
         sample_in = v ? wave(mode, n) : ~wave(mode, n);
         sample_valid = v;
         arm = arm_at > 0 && n == arm_at;
         if (v && n == trig_n) started = 1;
         if (started) begin
            nc++;
            if (v) nv++;
         end
         tick();
         if (started) decim = dec_after;
         if (v) n++;
         c++;
      end
      arm = 1'b0;
      sample_valid = 1'b0;
      if (stop == 0 && !frame_ready) chk("frame_ready_timeout", frame_ready, 1);
   endtask

   initial begin
      reset = 1'b1; arm = 1'b0; sample_valid = 1'b0; sample_in = '0;
      threshold = 6'd30; decim = 8'd0; rd_addr = '0;
      tick();
      tick();
      chk("rst_frame_ready", frame_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_timed_out", timed_out, 0);
      chk("rst_rd_data", rd_data, 0);
      reset = 1'b0;
      // edge trigger on square wave, armed while high; an arm mid-capture must be ignored
      do_arm(1'b1);
      chk("t1_busy", busy, 1);
      run(1, 0, 20, 100, 0, 8'd0, nval, ncyc);
      chk("t1_len", nval, 640);
      chk("t1_frame_ready", frame_ready, 1);
      chk("t1_busy_done", busy, 0);
      chk("t1_timed_out", timed_out, 0);
      readback(1);
      // read latency in DONE, including back-to-back address changes
      rd(5, 6'd60);
      rd(700, 6'd0);
      rd(15, 6'd0);
      rd(5, 6'd60);
      req = 1'b0;
      tick();
      tick();
      // decimation by 4: threshold 0 can never be undercut, so this frame is auto-triggered;
      // arm on an invalid cycle from DONE, and change decim after the trigger
      threshold = 6'd0;
      decim = 8'd3;
      do_arm(1'b0);
      chk("t2_rearm_frame_ready", frame_ready, 0);
      chk("t2_rearm_busy", busy, 1);
      run(2, 0, 100, 0, 0, 8'd0, nval, ncyc);
      chk("t2_len", nval, 1 + 639 * 4);
      chk("t2_timed_out", timed_out, 1);
      readback(2);
      // auto trigger on constant 0
      threshold = 6'd30;
      decim = 8'd0;
      do_arm(1'b1);
      chk("t3_timed_out_cleared", timed_out, 0);
      run(3, 0, 100, 0, 0, 8'd0, nval, ncyc);
      chk("t3_len", nval, 640);
      chk("t3_timed_out", timed_out, 1);
      readback(3);
      // reset 200 samples into capture, then a fresh full frame
      do_arm(1'b1);
      run(1, 0, 20, 0, 220, 8'd0, nval, ncyc);
      chk("t4_busy_before", busy, 1);
      reset = 1'b1;
      sample_valid = 1'b1;
      sample_in = 6'd60;
      tick();
      chk("t4_busy", busy, 0);
      chk("t4_frame_ready", frame_ready, 0);
      chk("t4_rd_data", rd_data, 0);
      reset = 1'b0;
      sample_valid = 1'b0;
      tick();
      chk("t4_idle_busy", busy, 0);
      do_arm(1'b1);
      run(1, 0, 20, 0, 0, 8'd0, nval, ncyc);
      chk("t4_len", nval, 640);
      chk("t4_timed_out", timed_out, 0);
      readback(1);
      // valid toggling every clock: 640 valid samples interleaved with 639 idle clocks
      do_arm(1'b1);
      run(1, 1, 20, 0, 0, 8'd0, nval, ncyc);
      chk("t6_len", nval, 640);
      chk("t6_clocks", ncyc, 2 * 640 - 1);
      chk("t6_timed_out", timed_out, 0);
      readback(1);
      chk("rd_queue_drained", q_rd.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
